// File: rtl/n_bit_round_rubin_arbiter_rr_priority_encoder.sv
// Wrap-around first-set search: returns the first requesting index met when
// scanning start, start+1, ... modulo BUS_WIDTH (not modulo 2**IDX_W).
module rr_priority_encoder #(
  parameter int BUS_WIDTH = 4,
  parameter int IDX_W     = $clog2(BUS_WIDTH)
) (
  input  logic [BUS_WIDTH-1:0] req_i,
  input  logic [IDX_W-1:0]     start_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     grant_o
);

  // Scan from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    for (int k = BUS_WIDTH - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(start_i) + k) % BUS_WIDTH;
      if (req_i[idx]) begin
        found_o = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/n_bit_round_rubin_arbiter.sv
// Round-robin arbiter whose only state is the registered grant index, which
// also serves as the pointer for the next search.
module n_bit_round_rubin_arbiter #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arbitration_ack,
  input  logic [BUS_WIDTH-1:0]         interrupt_bus,
  output logic [$clog2(BUS_WIDTH)-1:0] bus_priority
);

  localparam int IDX_W = $clog2(BUS_WIDTH);

  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] start;
  logic             found;
  logic [IDX_W-1:0] grant;

  // The current holder is placed last in the search order.
  assign start = (prio_q == IDX_W'(BUS_WIDTH - 1)) ? '0 : prio_q + 1'b1;

  rr_priority_encoder #(
    .BUS_WIDTH (BUS_WIDTH),
    .IDX_W     (IDX_W)
  ) u_enc (
    .req_i   (interrupt_bus),
    .start_i (start),
    .found_o (found),
    .grant_o (grant)
  );

  always_comb begin
    prio_d = prio_q;
    if (arbitration_ack && found) prio_d = grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= '0;
    else      prio_q <= prio_d;
  end

  assign bus_priority = prio_q;

endmodule

// File: tb/tb_n_bit_round_rubin_arbiter.sv
// Bench for the round-robin arbiter at BUS_WIDTH=3: vector table, corner
// sequences around asynchronous reset, and randomized traffic vs. a model.
module tb_n_bit_round_rubin_arbiter;

  localparam int BW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [2:0] req;
  logic [1:0] prio;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  n_bit_round_rubin_arbiter #(.BUS_WIDTH(BW)) dut (
    .clk             (clk),
    .rst             (rst),
    .arbitration_ack (ack),
    .interrupt_bus   (req),
    .bus_priority    (prio)
  );

  typedef struct {
    bit         rst_before;
    bit         ack;
    logic [2:0] req;
    int         exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Asynchronous reset pulse issued between edges; output must clear at once.
  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", int'(prio), 0);
    @(posedge clk);
    #1;
    check("rst_held_over_edge", int'(prio), 0);
    rst = 1'b1;
  endtask

  task automatic step(input bit a, input logic [2:0] r);
    ack = a;
    req = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit rb, input bit a, input logic [2:0] r, input int e);
    vec_t v;
    v.rst_before = rb; v.ack = a; v.req = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Reference: list the candidates in round-robin order after the last grant
  // and take the first one that is requesting.
  function automatic int model_next(input int last, input bit a, input logic [2:0] r);
    int order[$];
    if (!a) return last;
    for (int off = 1; off <= BW; off++) order.push_back((last + off) % BW);
    foreach (order[i]) if (r[order[i]]) return order[i];
    return last;
  endfunction

  initial begin
    int p;
    bit a;
    logic [2:0] r;

    rst = 1'b0;
    ack = 1'b1;
    req = 3'b111;
    #1;
    check("rst_before_any_edge", int'(prio), 0);
    @(posedge clk);
    #1;
    check("rst_ignores_ack", int'(prio), 0);
    rst = 1'b1;

    // All requesting
    add(1'b0, 1'b1, 3'b111, 1); add(1'b0, 1'b1, 3'b111, 2);
    add(1'b0, 1'b1, 3'b111, 0); add(1'b0, 1'b1, 3'b111, 1);
    // Sparse wrap, then holds at 2
    add(1'b1, 1'b1, 3'b101, 2); add(1'b0, 1'b1, 3'b101, 0);
    add(1'b0, 1'b1, 3'b101, 2);
    add(1'b0, 1'b0, 3'b111, 2); add(1'b0, 1'b1, 3'b000, 2);
    // Sweep 0..7 from reset
    add(1'b1, 1'b1, 3'd0, 0); add(1'b0, 1'b1, 3'd1, 0);
    add(1'b0, 1'b1, 3'd2, 1); add(1'b0, 1'b1, 3'd3, 0);
    add(1'b0, 1'b1, 3'd4, 2); add(1'b0, 1'b1, 3'd5, 0);
    add(1'b0, 1'b1, 3'd6, 1); add(1'b0, 1'b1, 3'd7, 2);
    // Sole requester is re-granted
    add(1'b0, 1'b1, 3'b100, 2);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) pulse_reset();
      step(vecs[i].ack, vecs[i].req);
      check($sformatf("vec%0d", i), int'(prio), vecs[i].exp);
    end

    // Reset mid-sequence while holding 2
    pulse_reset();
    step(1'b1, 3'b100);
    check("mid_pre", int'(prio), 2);
    pulse_reset();
    step(1'b1, 3'b111);
    check("mid_post_first_grant", int'(prio), 1);

    // Randomized traffic
    p = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        pulse_reset();
        p = 0;
      end
      a = ($urandom_range(0, 3) != 0);
      r = 3'($urandom);
      step(a, r);
      p = model_next(p, a, r);
      check($sformatf("rand%0d", i), int'(prio), p);
      if (prio >= 2'(BW)) check("range", int'(prio), BW - 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
